// File: rtl/dab_pwm_gen.sv
// Phase-shifted full-bridge PWM generator for a dual active bridge.
// Shared master count, per-channel phase/width and per-leg deadtime.
module dab_pwm_gen #(
    parameter int N_CH  = 2,
    parameter int CNT_W = 19,
    parameter int DT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  sync,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CNT_W-1:0]      half_per,
    input  logic [N_CH*CNT_W-1:0] tau,
    input  logic [N_CH*CNT_W-1:0] phi,
    input  logic [DT_W-1:0]       deadtime,
    output logic                  cfg_err,
    output logic [N_CH*2-1:0]     v,
    output logic [N_CH*4-1:0]     gate,
    output logic                  trigger,
    output logic                  per_start
);
    localparam int CW = CNT_W + 1;
    localparam int NL = 2 * N_CH;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    logic [1:0]            state;
    logic [CW-1:0]         cnt;
    logic                  loaded;
    logic                  pend;
    logic                  fresh;
    logic [CNT_W-1:0]      h_act;
    logic [CNT_W-1:0]      h_pnd;
    logic [N_CH*CNT_W-1:0] tau_act;
    logic [N_CH*CNT_W-1:0] tau_pnd;
    logic [N_CH*CNT_W-1:0] phi_act;
    logic [N_CH*CNT_W-1:0] phi_pnd;
    logic [DT_W-1:0]       dt_act;
    logic [DT_W-1:0]       dt_pnd;
    logic [CW-1:0]         two_h;
    logic [CW-1:0]         h_w;
    logic [CW-1:0]         ph_w [N_CH];
    logic [CW-1:0]         tw_w [N_CH];
    logic [CW-1:0]         lc [N_CH];
    logic [NL-1:0]         req;
    logic [NL-1:0]         req_q;
    logic [DT_W-1:0]       run_q [NL];
    logic [DT_W-1:0]       run_len [NL];
    logic [N_CH*2-1:0]     v_nxt;
    logic [N_CH*4-1:0]     g_nxt;
    logic                  cfg_ok;
    logic                  run;
    logic                  wrap;
    logic                  accept;
    logic                  apply;

    assign two_h     = {h_act, 1'b0};
    assign h_w       = {1'b0, h_act};
    assign run       = (state == S_RUN);
    assign wrap      = run && (cnt == two_h - CW'(1));
    assign cfg_ready = !pend;
    assign accept    = cfg_valid && !pend && cfg_ok;
    assign apply     = pend && (!run || wrap);

    always_comb begin
        cfg_ok = (half_per >= CNT_W'(2));
        for (int c = 0; c < N_CH; c++) begin
            if (tau[c*CNT_W +: CNT_W] > half_per)
                cfg_ok = 1'b0;
            if ({1'b0, phi[c*CNT_W +: CNT_W]} >= {half_per, 1'b0})
                cfg_ok = 1'b0;
        end
    end

    // lc wraps modulo 2H with a compare instead of a divider
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign ph_w[c] = {1'b0, phi_act[c*CNT_W +: CNT_W]};
        assign tw_w[c] = {1'b0, tau_act[c*CNT_W +: CNT_W]};
        assign lc[c] = (cnt >= ph_w[c]) ? cnt - ph_w[c]
                                        : cnt + two_h - ph_w[c];
        assign req[2*c] = (lc[c] >= h_w - tw_w[c]) &&
                          (lc[c] < two_h - tw_w[c]);
        assign req[2*c+1] = (lc[c] >= h_w);
        assign v_nxt[2*c +: 2] = {req[2*c+1] & ~req[2*c],
                                  req[2*c] ^ req[2*c+1]};
    end

    // run_len counts prior cycles the leg request has held steady
    always_comb begin
        g_nxt = '0;
        for (int l = 0; l < NL; l++) begin
            if (fresh || (req[l] != req_q[l]))
                run_len[l] = '0;
            else if (&run_q[l])
                run_len[l] = run_q[l];
            else
                run_len[l] = run_q[l] + DT_W'(1);
            g_nxt[2*l]   = req[l] && (run_len[l] >= dt_act);
            g_nxt[2*l+1] = !req[l] && (run_len[l] >= dt_act);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            loaded    <= 1'b0;
            pend      <= 1'b0;
            fresh     <= 1'b1;
            h_act     <= '0;
            h_pnd     <= '0;
            tau_act   <= '0;
            tau_pnd   <= '0;
            phi_act   <= '0;
            phi_pnd   <= '0;
            dt_act    <= '0;
            dt_pnd    <= '0;
            req_q     <= '0;
            v         <= '0;
            gate      <= '0;
            trigger   <= 1'b0;
            per_start <= 1'b0;
            cfg_err   <= 1'b0;
            for (int l = 0; l < NL; l++)
                run_q[l] <= '0;
        end else begin
            cfg_err <= cfg_valid && !pend && !cfg_ok;
            if (accept) begin
                pend    <= 1'b1;
                h_pnd   <= half_per;
                tau_pnd <= tau;
                phi_pnd <= phi;
                dt_pnd  <= deadtime;
            end else if (apply) begin
                pend    <= 1'b0;
                loaded  <= 1'b1;
                h_act   <= h_pnd;
                tau_act <= tau_pnd;
                phi_act <= phi_pnd;
                dt_act  <= dt_pnd;
            end

            if (!en) begin
                state <= S_IDLE;
                cnt   <= '0;
            end else begin
                case (state)
                    S_IDLE:  if (loaded) state <= S_ARMED;
                    S_ARMED: if (sync) state <= S_RUN;
                    S_RUN:   cnt <= wrap ? '0 : cnt + CW'(1);
                    default: state <= S_IDLE;
                endcase
            end

            fresh <= !run;
            req_q <= req;
            run_q <= run_len;

            if (run) begin
                v         <= v_nxt;
                gate      <= g_nxt;
                trigger   <= (cnt < h_w);
                per_start <= (cnt == '0);
            end else begin
                v         <= '0;
                gate      <= '0;
                trigger   <= 1'b0;
                per_start <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_dab_pwm_gen.sv
// Bench for dab_pwm_gen: directed waveform pins plus randomized traffic
// compared every cycle against a behavioural model.
module tb_dab_pwm_gen;
    localparam int NC = 2;
    localparam int CW = 19;
    localparam int DW = 8;

    logic            clk;
    logic            rst_n;
    logic            en;
    logic            sync;
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CW-1:0]   half_per;
    logic [NC*CW-1:0] tau;
    logic [NC*CW-1:0] phi;
    logic [DW-1:0]   deadtime;
    logic            cfg_err;
    logic [NC*2-1:0] v;
    logic [NC*4-1:0] gate;
    logic            trigger;
    logic            per_start;

    dab_pwm_gen #(.N_CH(NC), .CNT_W(CW), .DT_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .sync(sync),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .half_per(half_per), .tau(tau), .phi(phi),
        .deadtime(deadtime), .cfg_err(cfg_err), .v(v),
        .gate(gate), .trigger(trigger), .per_start(per_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model: 0=IDLE 1=ARMED 2=RUN
    int m_state, m_cnt, m_h, m_dt, p_h, p_dt, hn;
    int m_tau [NC];
    int m_phi [NC];
    int p_tau [NC];
    int p_phi [NC];
    bit m_loaded, m_pend;
    bit hr [2*NC][512];
    logic [NC*2-1:0] e_v;
    logic [NC*4-1:0] e_gate;
    bit e_trig, e_ps, e_err;

    logic [NC*2-1:0] rv [20];
    logic [NC*4-1:0] rg [20];
    bit rt [20];
    bit rp [20];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit in_ok();
        int h;
        bit ok;
        h = int'(half_per);
        ok = (h >= 2);
        for (int c = 0; c < NC; c++) begin
            if (int'(tau[c*CW +: CW]) > h) ok = 0;
            if (int'(phi[c*CW +: CW]) >= 2 * h) ok = 0;
        end
        return ok;
    endfunction

    task automatic model_step();
        int lc, st0, ld0;
        bit wr0, ok, r, ra, rb, acc_ok;
        if (!rst_n) begin
            e_v = '0; e_gate = '0;
            e_trig = 0; e_ps = 0; e_err = 0;
            m_state = 0; m_cnt = 0; m_loaded = 0; m_pend = 0; hn = 0;
            return;
        end
        acc_ok = in_ok();
        e_err = cfg_valid && !m_pend && !acc_ok;
        if (m_state == 2) begin
            for (int c = 0; c < NC; c++) begin
                lc = (m_cnt + 2 * m_h - m_phi[c]) % (2 * m_h);
                ra = (lc >= m_h - m_tau[c]) && (lc < 2 * m_h - m_tau[c]);
                rb = (lc >= m_h);
                hr[2*c][hn % 512] = ra;
                hr[2*c+1][hn % 512] = rb;
                e_v[2*c +: 2] = (ra && !rb) ? 2'b01 :
                                (rb && !ra) ? 2'b11 : 2'b00;
            end
            for (int l = 0; l < 2 * NC; l++) begin
                r = hr[l][hn % 512];
                ok = (hn >= m_dt);
                if (ok)
                    for (int i = 1; i <= m_dt; i++)
                        if (hr[l][(hn - i) % 512] != r) ok = 0;
                e_gate[2*l] = ok && r;
                e_gate[2*l+1] = ok && !r;
            end
            hn++;
            e_trig = (m_cnt < m_h);
            e_ps = (m_cnt == 0);
        end else begin
            e_v = '0; e_gate = '0; e_trig = 0; e_ps = 0; hn = 0;
        end
        st0 = m_state;
        ld0 = m_loaded;
        wr0 = (m_state == 2) && (m_cnt == 2 * m_h - 1);
        if (!en) begin
            m_state = 0; m_cnt = 0;
        end else if (st0 == 0) begin
            if (ld0) m_state = 1;
        end else if (st0 == 1) begin
            if (sync) m_state = 2;
            m_cnt = 0;
        end else begin
            m_cnt = wr0 ? 0 : m_cnt + 1;
        end
        if (m_pend && (st0 != 2 || wr0)) begin
            m_h = p_h; m_dt = p_dt; m_pend = 0; m_loaded = 1;
            for (int c = 0; c < NC; c++) begin
                m_tau[c] = p_tau[c]; m_phi[c] = p_phi[c];
            end
        end else if (cfg_valid && !m_pend && acc_ok) begin
            m_pend = 1;
            p_h = int'(half_per); p_dt = int'(deadtime);
            for (int c = 0; c < NC; c++) begin
                p_tau[c] = int'(tau[c*CW +: CW]);
                p_phi[c] = int'(phi[c*CW +: CW]);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        chk("cfg_ready", 32'(cfg_ready), 32'(!m_pend));
        chk("cfg_err", 32'(cfg_err), 32'(e_err));
        chk("v", 32'(v), 32'(e_v));
        chk("gate", 32'(gate), 32'(e_gate));
        chk("trigger", 32'(trigger), 32'(e_trig));
        chk("per_start", 32'(per_start), 32'(e_ps));
        for (int l = 0; l < 2 * NC; l++)
            chk("overlap", 32'(gate[2*l] & gate[2*l+1]), 32'd0);
    end

    task automatic set_cfg(input int h, input int t0, input int t1,
                           input int p0, input int p1, input int d);
        half_per = CW'(h);
        tau = {CW'(t1), CW'(t0)};
        phi = {CW'(p1), CW'(p0)};
        deadtime = DW'(d);
    endtask

    task automatic wait_ps();
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (per_start) got = 1;
        end
        chk("wait_per_start", 32'(got), 32'd1);
    endtask

    task automatic wait_ready();
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            if (cfg_ready) got = 1;
        end
        chk("wait_cfg_ready", 32'(got), 32'd1);
    endtask

    task automatic rec_period();
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            rv[i] = v; rg[i] = gate; rt[i] = trigger; rp[i] = per_start;
        end
    endtask

    task automatic offer();
        cfg_valid = 1;
        tick();
        cfg_valid = 0;
    endtask

    initial begin
        int n, e0, e1, rh;
        bit sw;
        rst_n = 0; en = 0; sync = 0; cfg_valid = 0;
        set_cfg(0, 0, 0, 0, 0, 0);
        repeat (3) tick();
        chk("rst_ready", 32'(cfg_ready), 32'd1);
        chk("rst_gate", 32'(gate), 32'd0);
        chk("rst_v", 32'(v), 32'd0);
        chk("rst_trig", 32'(trigger), 32'd0);

        rst_n = 1; en = 1;
        set_cfg(10, 4, 4, 0, 5, 0);
        offer();
        sync = 1;
        wait_ps();
        rec_period();
        for (int i = 0; i < 20; i++) begin
            e0 = (i >= 6 && i <= 9) ? 1 : (i >= 16) ? 3 : 0;
            e1 = (i >= 11 && i <= 14) ? 1 : (i >= 1 && i <= 4) ? 3 : 0;
            chk("sq_ch0", 32'(rv[i][1:0]), 32'(e0));
            chk("sq_ch1", 32'(rv[i][3:2]), 32'(e1));
            chk("sq_trig", 32'(rt[i]), 32'(i < 10));
            chk("sq_ps", 32'(rp[i]), 32'(i == 0));
        end

        set_cfg(10, 4, 4, 0, 5, 2);
        offer();
        chk("acc_ready_low", 32'(cfg_ready), 32'd0);
        wait_ready();
        wait_ps();
        rec_period();
        chk("dt_idx5", 32'(rg[5][1:0]), 32'd2);
        chk("dt_idx6", 32'(rg[6][1:0]), 32'd0);
        chk("dt_idx7", 32'(rg[7][1:0]), 32'd0);
        chk("dt_idx8", 32'(rg[8][1:0]), 32'd1);
        chk("dt_v6", 32'(rv[6][1:0]), 32'd1);

        repeat (11) tick();
        set_cfg(10, 8, 8, 0, 5, 2);
        offer();
        chk("mid_ready_low", 32'(cfg_ready), 32'd0);
        repeat (2) tick();
        chk("mid_old_width", 32'(v[1:0]), 32'd0);
        wait_ready();
        wait_ps();
        rec_period();
        chk("new_ch0_2", 32'(rv[2][1:0]), 32'd1);
        chk("new_ch0_13", 32'(rv[13][1:0]), 32'd3);
        chk("new_ch1_7", 32'(rv[7][3:2]), 32'd1);
        chk("new_ch1_0", 32'(rv[0][3:2]), 32'd3);
        chk("new_ch1_15", 32'(rv[15][3:2]), 32'd0);

        set_cfg(10, 11, 4, 0, 5, 2);
        offer();
        chk("rej_err", 32'(cfg_err), 32'd1);
        chk("rej_ready", 32'(cfg_ready), 32'd1);
        tick();
        chk("rej_err_pulse", 32'(cfg_err), 32'd0);

        set_cfg(10, 10, 0, 0, 5, 0);
        offer();
        wait_ready();
        wait_ps();
        rec_period();
        for (int i = 0; i < 20; i++) begin
            chk("full_ch0", 32'(rv[i][1:0]), 32'(i < 10 ? 1 : 3));
            chk("zero_ch1", 32'(rv[i][3:2]), 32'd0);
        end
        chk("t0_ahi_0", 32'(rg[0][4]), 32'd1);
        chk("t0_ahi_10", 32'(rg[10][4]), 32'd0);
        chk("t0_alo_10", 32'(rg[10][5]), 32'd1);
        wait_ps();
        n = 0;
        do begin
            tick();
            n++;
        end while (!per_start && n < 100);
        chk("ps_period", 32'(n), 32'd20);

        repeat (6) tick();
        rst_n = 0;
        tick();
        chk("mrst_gate", 32'(gate), 32'd0);
        chk("mrst_v", 32'(v), 32'd0);
        chk("mrst_ps", 32'(per_start), 32'd0);
        chk("mrst_ready", 32'(cfg_ready), 32'd1);
        rst_n = 1; en = 1; sync = 1;
        sw = 0;
        repeat (30) begin
            tick();
            if (gate != '0) sw = 1;
        end
        chk("no_switch_after_rst", 32'(sw), 32'd0);
        set_cfg(10, 4, 4, 0, 5, 1);
        offer();
        repeat (40) tick();

        for (int k = 0; k < 4000; k++) begin
            rst_n = ($urandom_range(0, 299) != 0);
            en = ($urandom_range(0, 149) != 0);
            sync = ($urandom_range(0, 3) == 0);
            cfg_valid = ($urandom_range(0, 11) == 0);
            rh = int'($urandom_range(0, 20));
            set_cfg(rh,
                    int'($urandom_range(0, rh + 1)),
                    int'($urandom_range(0, rh + 1)),
                    int'($urandom_range(0, 2 * rh)),
                    int'($urandom_range(0, 2 * rh)),
                    int'($urandom_range(0, 4)));
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dab_pwm_gen.md
DAB_PWM_GEN -- requirements
Module: dab_pwm_gen

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of full-bridge channels.
REQ-002 SHALL have parameter CNT_W, default 19: width of half-period, tau and phi values in clock counts.
REQ-003 SHALL have parameter DT_W, default 8: width of the deadtime value.
REQ-004 SHALL have ports: clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 en  in  1  run enable.
REQ-007 sync  in  1  start trigger, sampled in ARMED.
REQ-008 cfg_valid  in  1  config set offered.
REQ-009 cfg_ready  out  1  config set can be accepted.
REQ-010 half_per  in  CNT_W  half switching period H, in counts.
REQ-011 tau  in  N_CH*CNT_W  per-channel pulse width; channel c at [c*CNT_W +: CNT_W].
REQ-012 phi  in  N_CH*CNT_W  per-channel phase delay, unsigned, 0..2H-1.
REQ-013 deadtime  in  DT_W  leg deadtime, in counts.
REQ-014 cfg_err  out  1  one-cycle pulse on a rejected set.
REQ-015 v  out  N_CH*2  signed bridge voltage per channel: +1, 0 or -1.
REQ-016 gate  out  N_CH*4  per channel [4c+0] A_hi, [4c+1] A_lo, [4c+2] B_hi, [4c+3] B_lo.
REQ-017 trigger  out  1  high while the master count is below H.
REQ-018 per_start  out  1  one-cycle pulse when the master count is 0.

Function
REQ-019 SHALL use FSM states IDLE, ARMED and RUN.
- IDLE->ARMED: en=1 and a valid config has been loaded.
- ARMED->RUN: sync=1.
- Any state->IDLE: en=0, taking effect on the next cycle.
REQ-020 SHALL run a master counter cnt of width CNT_W+1 only in RUN.
- cnt=0 in the first RUN cycle, increments by 1 each cycle, and wraps from 2H-1 to 0.
- cnt is held at 0 outside RUN.
REQ-021 SHALL compute the channel-local count without division.
- lc = cnt-phi when cnt>=phi; otherwise lc = cnt+2H-phi.
REQ-022 SHALL define the leg requests per channel.
- A_req = 1 when lc is in [H-tau, 2H-tau).
- B_req = 1 when lc is in [H, 2H).
- v = A_req - B_req.
REQ-023 SHALL register all outputs: v, gate, trigger and per_start at cycle k+1 reflect cnt at cycle k.
REQ-024 SHALL generate gates with deadtime per leg. On any change of the leg request:
- both switches of that leg go low immediately;
- the newly requested switch goes high after `deadtime` further cycles.
REQ-025 SHALL restart a running deadtime countdown if the leg request toggles during it.
REQ-026 SHALL give exact complementary switching with no gap when deadtime=0.
REQ-027 SHALL never drive hi and lo of the same leg high in the same cycle.
REQ-028 SHALL drive gate all low and v all 0 in IDLE and ARMED.
REQ-029 SHALL, in RUN, start each leg with both switches low for `deadtime` cycles before the first switch turns on.
REQ-030 SHALL hold cfg_ready=1 whenever no accepted set is pending.
- A set is accepted on the cycle where cfg_valid and cfg_ready are both 1.
- cfg_ready then drops until the set is applied.
REQ-031 SHALL validate each offered set, and reject the whole set if any of the following holds:
- H < 2;
- any tau > H;
- any phi >= 2H.
REQ-032 SHALL, on rejecting a set, pulse cfg_err for 1 cycle, keep the active set unchanged, and keep cfg_ready=1.
REQ-033 SHALL apply an accepted set at the following points:
- in IDLE or ARMED, on the next cycle;
- in RUN, on the cycle cnt wraps to 0, with all channels and H updated atomically.
REQ-034 SHALL handle the tau boundaries.
- tau=0: v stays 0 while the legs still switch.
- tau=H: v is a full square wave, +1 for lc<H and -1 for lc>=H.
REQ-035 SHALL give priority to en=0 over a simultaneous sync or wrap.
REQ-036 SHALL restart a re-armed run from cnt=0.

Reset
REQ-037 SHALL, on rst_n=0 at a rising edge:
- set state to IDLE and cnt to 0;
- set v=0, gate=0, trigger=0, per_start=0, cfg_err=0;
- set cfg_ready=1;
- clear the loaded-config flag and any pending set.
REQ-038 SHALL let reset asserted mid-RUN force all gates low on the next edge.
REQ-039 SHALL require a new config set and a new sync after reset before switching resumes.

Verification
REQ-040 Setup: N_CH=2, H=10, tau={4,4}, phi={0,5}, deadtime=0, en=1, then sync.
- ch0 v=+1 at cnt 6..9 and -1 at cnt 16..19.
- ch1 v=+1 at cnt 11..14 and -1 at cnt 1..4.
- Both with 1-cycle latency.
REQ-041 Same setup with deadtime=2.
- On each A_req rise, A_lo falls and A_hi rises 2 cycles later.
- Never A_hi=A_lo=1.
REQ-042 Mid-period, offer tau={8,8} with cfg_valid.
- Accepted; cfg_ready=0 until the wrap.
- New pulse widths appear only from the next cnt=0.
REQ-043 Offer tau={11,4} with H=10.
- cfg_err pulses 1 cycle; output waveform unchanged.
REQ-044 Assert rst_n=0 at cnt=7 in RUN.
- Next cycle all outputs 0 and state IDLE.
- No switching until a new config and sync.
REQ-045 Set tau={10,0}.
- ch0 gives a square wave, +1 at cnt 0..9 and -1 at cnt 10..19.
- ch1 v stays 0.
- per_start pulses every 20 cycles.
